uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, meaning sys_clk_i cycles per bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter PARITY_ODD, default 0, selecting odd (1) or even (0) parity; it is used only when UART_RX_PARITY_EN is defined.
REQ-003 SHALL have port sys_clk_i, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port uart_rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port uart_dat_o, output, 8 bits: received byte.
REQ-007 SHALL have port uart_valid_o, output, 1 bit: uart_dat_o holds an unread byte.
REQ-008 SHALL have port uart_ack_i, input, 1 bit: consumer takes the byte; ignored while uart_valid_o=0.
REQ-009 SHALL have port uart_busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port uart_frame_err_o, output, 1 bit: one-cycle pulse on a bad stop bit (or bad parity).
REQ-011 SHALL have port uart_overrun_o, output, 1 bit: sticky flag for a byte lost because the holding register was full.

Function
REQ-012 SHALL pass uart_rx_i through a 2-flop synchronizer; both flops reset to 1; the FSM sees only the synchronized value.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN), STOP and WAIT_HIGH.
REQ-014 SHALL, in IDLE, on a synchronized 0, go to START and clear the bit counter.
REQ-015 SHALL, in START, sample after BAUD_DIV/2 cycles (integer divide): 1 -> back to IDLE with no flags (glitch reject); 0 -> go to DATA.
REQ-016 SHALL, in DATA, sample every BAUD_DIV cycles, shift 8 bits LSB first, then go to PARITY or STOP.
REQ-017 SHALL, in STOP, sample after BAUD_DIV cycles; the stop bit is good when the sample is 1.
REQ-018 SHALL handle a good stop bit by delivering the byte in the next cycle and returning to IDLE; the next start bit is accepted immediately, with no extra idle time required.
REQ-019 SHALL handle a bad stop bit by pulsing uart_frame_err_o for 1 cycle, discarding the byte and going to WAIT_HIGH, which stays until the synchronized line is 1, then goes to IDLE (break tolerance).
REQ-020 SHALL use delivery latency = BAUD_DIV/2 + 9*BAUD_DIV (+BAUD_DIV with parity) cycles from IDLE seeing 0 to the stop sample; uart_valid_o rises in the following cycle.
REQ-021 SHALL treat the output register as one-entry: uart_dat_o is stable while uart_valid_o=1; uart_valid_o falls in the cycle after uart_ack_i=1.
REQ-022 SHALL handle delivery in the same cycle as an ack by loading the new byte with uart_valid_o staying 1 and no overrun.
REQ-023 SHALL handle delivery while uart_valid_o=1 with no ack by keeping the old byte, dropping the new byte and setting uart_overrun_o=1.
REQ-024 SHALL clear uart_overrun_o on any cycle with uart_ack_i=1 and uart_valid_o=1, unless a new overrun occurs in that same cycle, in which case it stays set.
REQ-025 SHALL keep the baud counter wide enough for BAUD_DIV-1 and wrap it to 0 at each sample; the counter never free-runs outside a frame.

Reset
REQ-026 SHALL, when sys_rst_i=1 at a clock edge, go to IDLE and set uart_dat_o=0x00, uart_valid_o=0, uart_busy_o=0, uart_frame_err_o=0, uart_overrun_o=0, with counters at 0 and synchronizer at 1.
REQ-027 SHALL, on reset mid-frame, abandon the partial byte silently; reception resumes on the first falling edge after reset is released.

Configuration
REQ-028 SHALL provide macro UART_RX_PARITY_EN: when defined, a parity bit is sampled after bit 7; a mismatch against PARITY_ODD is treated as a framing error (pulse, discard, then STOP handling continues to WAIT_HIGH/IDLE).
REQ-029 SHALL, without UART_RX_PARITY_EN, build no PARITY state or logic: the frame is 8N1 and PARITY_ODD is unused.

Verification (BAUD_DIV=8)
REQ-030 SHALL test: 8N1 frame 0xA5 with good stop -> uart_valid_o rises 79 cycles after the line falling edge, uart_dat_o=0xA5.
REQ-031 SHALL test: 3-cycle low glitch on an idle line -> no valid, no frame_err, uart_busy_o back to 0 within 8 cycles.
REQ-032 SHALL test: frame 0x3C with stop bit 0, line then held low 40 cycles -> one frame_err pulse, no valid, busy stays high until the line returns high.
REQ-033 SHALL test: bytes 0x11 then 0x22 with no ack -> uart_dat_o=0x11, uart_overrun_o=1; then ack -> valid falls, overrun clears.
REQ-034 SHALL test: ack asserted in the exact delivery cycle of 0x22 while 0x11 is pending -> uart_dat_o=0x22, valid stays 1, overrun stays 0.
REQ-035 SHALL test: sys_rst_i pulsed during bit 4 of 0xFF, then 0x5A sent -> only 0x5A delivered, all flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 8N1 framing (optional parity via
// UART_RX_PARITY_EN), one-entry output register with ack/overrun.
// Ports: sys_clk_i/sys_rst_i clock and sync high reset; uart_rx_i line;
// uart_dat_o/uart_valid_o/uart_ack_i byte handoff; uart_busy_o frame in
// progress; uart_frame_err_o error pulse; uart_overrun_o sticky byte loss.
module uart_rx #(
  parameter int BAUD_DIV   = 434,
  parameter int PARITY_ODD = 0
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_ack_i,
  output logic       uart_busy_o,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  if (BAUD_DIV < 4 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_param_chk
    $error("uart_rx: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shift;
  logic          full_hit;
  logic          half_hit;
  logic          discard;

  assign rx_s        = sync[1];
  assign full_hit    = (cnt == FULL);
  assign half_hit    = (cnt == HALF);
  assign uart_busy_o = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign discard = par_err;
`else
  assign discard = 1'b0;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state            <= IDLE;
      sync             <= 2'b11;
      cnt              <= '0;
      bitn             <= 3'd0;
      shift            <= 8'h00;
      uart_dat_o       <= 8'h00;
      uart_valid_o     <= 1'b0;
      uart_frame_err_o <= 1'b0;
      uart_overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err          <= 1'b0;
`endif
    end else begin
      sync             <= {sync[0], uart_rx_i};
      uart_frame_err_o <= 1'b0;

      // Consumer read; a delivery below in the same cycle overrides.
      if (uart_valid_o && uart_ack_i) begin
        uart_valid_o   <= 1'b0;
        uart_overrun_o <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          cnt  <= '0;
          bitn <= 3'd0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (half_hit) begin
            cnt   <= '0;
            // High at mid-start means a glitch, not a frame.
            state <= rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (full_hit) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (full_hit) begin
            cnt   <= '0;
            state <= STOP;
            if ((^shift ^ rx_s) != PARITY_ODD[0]) begin
              par_err          <= 1'b1;
              uart_frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (full_hit) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!discard) begin
                if (uart_valid_o && !uart_ack_i) begin
                  uart_overrun_o <= 1'b1;
                end else begin
                  uart_dat_o   <= shift;
                  uart_valid_o <= 1'b1;
                end
              end
            end else begin
              // Line held low: wait out a break before rearming.
              state <= WAIT_HIGH;
              if (!discard) uart_frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at BAUD_DIV=8: directed corner sequences,
// a vector table and randomized frames against a frame-level model.
module tb_uart_rx;

  localparam int BD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       ovr;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;

  uart_rx #(.BAUD_DIV(BD), .PARITY_ODD(0)) dut (
    .sys_clk_i       (clk),
    .sys_rst_i       (rst),
    .uart_rx_i       (rx),
    .uart_dat_o      (dat),
    .uart_valid_o    (valid),
    .uart_ack_i      (ack),
    .uart_busy_o     (busy),
    .uart_frame_err_o(frame_err),
    .uart_overrun_o  (ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_err) fe_cnt = fe_cnt + 1;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       pre_ack;
    logic       exp_valid;
    logic [7:0] exp_dat;
    logic       exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    idle(2);
  endtask

  // Bit-bangs one frame; rise = tick count of first valid 0->1.
  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input int ack_at,
                            input int rst_at,
                            output int rise);
    logic prev;
    rise = -1;
    prev = valid;
    for (int t = 0; t < 10 * BD; t++) begin
      int b;
      b = t / BD;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else             rx = stop;
      ack = (t == ack_at);
      rst = (t == rst_at);
      tick();
      if (valid && !prev && rise < 0) rise = t + 1;
      prev = valid;
    end
    ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    int r;
    send_frame(d, stop, -1, -1, r);
    rx = 1'b1;
    idle(6);
  endtask

  initial begin
    int rise;
    int fe0;
    logic       m_valid;
    logic [7:0] m_dat;
    logic       m_ovr;

    tbl[0] = '{8'hA5, 1, 0, 1, 8'hA5, 0, 0};
    tbl[1] = '{8'h11, 1, 1, 1, 8'h11, 0, 0};
    tbl[2] = '{8'h22, 1, 0, 1, 8'h11, 1, 0};
    tbl[3] = '{8'hC3, 1, 1, 1, 8'hC3, 0, 0};
    tbl[4] = '{8'h3C, 0, 1, 0, 8'hC3, 0, 1};
    tbl[5] = '{8'h00, 1, 0, 1, 8'h00, 0, 0};
    tbl[6] = '{8'hFF, 1, 0, 1, 8'h00, 1, 0};
    tbl[7] = '{8'h81, 0, 0, 1, 8'h00, 1, 1};
    tbl[8] = '{8'h7E, 1, 1, 1, 8'h7E, 0, 0};

    // Reset state
    do_reset();
    chk("rst_dat", dat, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ovr", ovr, 0);

    // Latency of a clean 8N1 frame
    send_frame(8'hA5, 1'b1, -1, -1, rise);
    chk("lat_rise", rise, 79);
    chk("lat_dat", dat, 8'hA5);
    idle(4);
    pulse_ack();
    chk("ack_valid", valid, 0);

    // Short low glitch on idle line
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(8);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", valid, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);

    // Bad stop bit followed by a long low line
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, -1, rise);
    idle(40);
    chk("brk_fe", fe_cnt - fe0, 1);
    chk("brk_valid", valid, 0);
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    idle(6);
    chk("brk_idle", busy, 0);

    // Overrun without ack, then ack
    do_reset();
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    chk("ovr_dat", dat, 8'h11);
    chk("ovr_flag", ovr, 1);
    chk("ovr_valid", valid, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("ovr_ack_valid", valid, 0);
    chk("ovr_ack_flag", ovr, 0);

    // Ack in the exact delivery cycle
    do_reset();
    send(8'h11, 1'b1);
    send_frame(8'h22, 1'b1, 10 * BD - 2, -1, rise);
    chk("same_dat", dat, 8'h22);
    chk("same_valid", valid, 1);
    chk("same_ovr", ovr, 0);

    // Reset during bit 4 of 0xFF
    do_reset();
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b1, -1, 5 * BD + 4, rise);
    chk("mrst_valid", valid, 0);
    idle(4);
    send(8'h5A, 1'b1);
    chk("mrst_dat", dat, 8'h5A);
    chk("mrst_vld", valid, 1);
    chk("mrst_ovr", ovr, 0);
    chk("mrst_fe", fe_cnt - fe0, 0);

    // Vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].pre_ack) pulse_ack();
      fe0 = fe_cnt;
      send(tbl[i].d, tbl[i].stop);
      chk($sformatf("tbl%0d_valid", i),
          valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_dat", i),
          dat, tbl[i].exp_dat);
      chk($sformatf("tbl%0d_ovr", i),
          ovr, tbl[i].exp_ovr);
      chk($sformatf("tbl%0d_fe", i),
          fe_cnt - fe0, tbl[i].exp_fe);
    end

    // Random frames against a frame-level model
    do_reset();
    m_valid = 1'b0;
    m_dat   = 8'h00;
    m_ovr   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      logic       stop;
      logic       pa;
      int         efe;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      pa   = 1'($urandom_range(0, 1));
      if (pa) begin
        pulse_ack();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
      end
      efe = 0;
      if (!stop) efe = 1;
      else if (m_valid) m_ovr = 1'b1;
      else begin
        m_dat   = d;
        m_valid = 1'b1;
      end
      fe0 = fe_cnt;
      send(d, stop);
      chk($sformatf("rnd%0d_valid", i), valid, m_valid);
      chk($sformatf("rnd%0d_dat", i), dat, m_dat);
      chk($sformatf("rnd%0d_ovr", i), ovr, m_ovr);
      chk($sformatf("rnd%0d_fe", i), fe_cnt - fe0, efe);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
